// File: rtl/image_scan_ctrl_pkg.sv
// Shared definitions for the image scan controller.
// Holds the default image geometry, the ROM address and pixel widths,
// the frame-size constant and the scan FSM state type.
package img_pkg;

  localparam int IMG_W      = 400;
  localparam int IMG_H      = 266;
  localparam int ADDR_W     = 17;
  localparam int PIX_W      = 24;
  localparam int FRAME_SIZE = IMG_W * IMG_H;

  // Number of sideband flag bits carried with each pixel: sof, eol, eof.
  localparam int FLAG_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/img_skid_fifo.sv
// Two-entry FIFO that decouples ROM reads from downstream backpressure.
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-low reset
//   push, data    - write strobe and write word
//   pop           - read strobe (ignored when empty)
//   head          - word at the head of the FIFO
//   full, empty   - occupancy status
//   count         - current occupancy (0..2)
module img_skid_fifo #(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle; the freed slot is the one the write pointer points at.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy. Simultaneous push and pop keep the
  // count unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/image_scan_ctrl.sv
// Image scan controller: walks a pixel ROM in raster order and streams
// the pixels out on a valid/ready interface with frame/line flags.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-low reset
//   start               - one-cycle frame-start request (honoured in IDLE)
//   rom_en, rom_addr    - ROM read strobe and address
//   rom_pixel           - ROM data, valid one cycle after rom_en
//   out_valid/out_ready - output handshake
//   out_pixel           - pixel data
//   out_sof/eol/eof     - first-of-frame, last-of-line, last-of-frame
//   busy                - controller is not idle
//   done                - one-cycle pulse at frame completion
// Configuration macro IMG_SCAN_CONTINUOUS_EN: when defined, the scan wraps
// back to address 0 after the last pixel and never leaves RUN.
module image_scan_ctrl #(
  parameter int IMG_W  = img_pkg::IMG_W,
  parameter int IMG_H  = img_pkg::IMG_H,
  parameter int ADDR_W = img_pkg::ADDR_W,
  parameter int PIX_W  = img_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pixel,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done
);
  import img_pkg::*;

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_H - 1);
  localparam int                FIFO_W    = PIX_W + FLAG_W;

  scan_state_t       state;
  scan_state_t       next_state;
  logic [ADDR_W-1:0] addr;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              at_last;
  logic [2:0]        issue_flags;
  logic              inflight;
  logic [2:0]        inflight_flags;
  logic [2:0]        room_used;
  logic              pop;
  logic              fifo_push;
  logic [FIFO_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;

  assign rom_addr = addr;
  assign at_last  = (addr == LAST_ADDR);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign pop      = out_ready && !fifo_empty;

  // Flags are computed from the raster position at issue time and travel
  // alongside the read so they land in the FIFO with their pixel.
  assign issue_flags = {(x == '0) && (y == '0), (x == X_LAST), (x == X_LAST) && (y == Y_LAST)};

  // Occupancy the FIFO will have after this edge, counting the read that
  // returns now and any beat leaving now. A new read is only launched when
  // that leaves room for it, which bounds outstanding pixels at two while
  // still allowing one read per cycle when the output drains every cycle.
  always_comb begin
    room_used = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    rom_en    = (state == RUN) && (room_used < 3'd2);
  end

  // Next-state logic. DRAIN finishes once nothing remains after this edge,
  // so DONE lands in the cycle right after the eof beat is accepted.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) next_state = RUN;
      end
      RUN: begin
`ifdef IMG_SCAN_CONTINUOUS_EN
        next_state = RUN;
`else
        if (rom_en && at_last) next_state = DRAIN;
`endif
      end
      DRAIN: begin
        if (!inflight && (room_used == 3'd0)) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Address and raster position advance together on every issued read and
  // wrap to the frame origin after the last pixel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr <= '0;
      x    <= '0;
      y    <= '0;
    end else if (rom_en) begin
      if (at_last) begin
        addr <= '0;
        x    <= '0;
        y    <= '0;
      end else begin
        addr <= addr + 1'b1;
        if (x == X_LAST) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  // One-deep record of the read whose data arrives from the ROM next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight       <= 1'b0;
      inflight_flags <= '0;
    end else begin
      inflight       <= rom_en;
      inflight_flags <= issue_flags;
    end
  end

  assign fifo_push = inflight && (!fifo_full || pop);

  img_skid_fifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .data  ({inflight_flags, rom_pixel}),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output beat comes straight from the FIFO head; data and flags read as
  // zero whenever no beat is presented.
  always_comb begin
    out_valid = !fifo_empty;
    out_pixel = fifo_empty ? '0 : fifo_head[PIX_W-1:0];
    out_sof   = !fifo_empty && fifo_head[PIX_W+2];
    out_eol   = !fifo_empty && fifo_head[PIX_W+1];
    out_eof   = !fifo_empty && fifo_head[PIX_W];
  end

endmodule
